// File: rtl/fwd_pkg.sv
// fwd_pkg: operand-B source encodings, tracked-entry record and stage-index width helper
package fwd_pkg;
  localparam logic [1:0] ALUSRC_REG = 2'b00;
  localparam logic [1:0] ALUSRC_IMM = 2'b01;
  localparam logic [1:0] ALUSRC_R15 = 2'b10;
  localparam logic [1:0] ALUSRC_RSV = 2'b11;
  localparam int MAX_RW = 8;
  typedef struct packed {
    logic              valid;
    logic [MAX_RW-1:0] dst;
    logic              wide;
    logic              late;
  } fwd_entry_t;
  function automatic int fwd_stage_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fwd_track_pipe.sv
// fwd_track_pipe: shift register of in-flight destination writes with flush and stall bubbles
module fwd_track_pipe import fwd_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   bubble,
  input  fwd_entry_t             issue,
  output fwd_entry_t [DEPTH-1:0] ent
);
  fwd_entry_t head;
  fwd_entry_t [DEPTH:0] chain;
  always_comb begin
    head = issue;
    head.valid = issue.valid & ~bubble;
  end
  // chain[0] is the incoming entry, chain[k] the current occupant of slot k-1
  assign chain = {ent, head};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ent <= '0;
    else if (flush) ent <= '0;
    else ent <= chain[DEPTH-1:0];
endmodule

// File: rtl/operand_forward_unit.sv
// operand_forward_unit: operand-B selector with producer tracking, forwarding and load-use stall
module operand_forward_unit import fwd_pkg::*; #(
  parameter int DW      = 16,
  parameter int RW      = 4,
  parameter int DEPTH   = 2,
  parameter int HI_REG  = 0,
  parameter int R15_REG = 15
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            issue_valid,
  input  logic [RW-1:0]                   issue_dst,
  input  logic                            issue_wide,
  input  logic                            issue_late,
  input  logic [DEPTH*2*DW-1:0]           stage_result,
  input  logic [RW-1:0]                   src_reg,
  input  logic [1:0]                      alusrc,
  input  logic [DW-1:0]                   op2,
  input  logic [DW-1:0]                   seimmd,
  input  logic [DW-1:0]                   r15,
  output logic [DW-1:0]                   result,
  output logic [fwd_stage_w(DEPTH)-1:0]   fwd_stage,
  output logic                            fwd_hi,
  output logic                            stall,
  output logic [15:0]                     stall_count
);
  localparam int FW = fwd_stage_w(DEPTH);
  fwd_entry_t issue;
  fwd_entry_t [DEPTH-1:0] ent;
  logic look;
  logic [RW-1:0] addr;
  logic [DEPTH-1:0] m_lo, m_hi, usable;
  logic [DW-1:0] nofwd;
  assign issue = '{valid: issue_valid, dst: MAX_RW'(issue_dst), wide: issue_wide, late: issue_late};
  fwd_track_pipe #(.DEPTH(DEPTH)) u_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .bubble (stall),
    .issue  (issue),
    .ent    (ent)
  );
  assign look  = alusrc == ALUSRC_REG || alusrc == ALUSRC_R15;
  assign addr  = alusrc == ALUSRC_R15 ? RW'(R15_REG) : src_reg;
  assign nofwd = alusrc == ALUSRC_REG ? op2 :
                 alusrc == ALUSRC_IMM ? seimmd :
                 alusrc == ALUSRC_RSV ? '0 : r15;
  for (genvar k = 0; k < DEPTH; k++) begin : g_m
    assign m_lo[k]   = ent[k].valid && ent[k].dst == MAX_RW'(addr);
    assign m_hi[k]   = ent[k].valid && ent[k].wide && addr == RW'(HI_REG);
    assign usable[k] = look && (m_lo[k] || m_hi[k]) && !(ent[k].late && k == 0);
  end
  // a late producer one stage ahead cannot be forwarded yet, so hold decode instead
  assign stall = look && (m_lo[0] || m_hi[0]) && ent[0].late;
  always_comb begin
    result = nofwd;
    fwd_stage = '0;
    fwd_hi = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--)
      if (usable[k] && !stall) begin
        result = m_lo[k] ? stage_result[k*2*DW +: DW] : stage_result[k*2*DW+DW +: DW];
        fwd_stage = FW'(k + 1);
        fwd_hi = !m_lo[k];
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_count <= '0;
    else if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
endmodule

// File: tb/tb_operand_forward_unit.sv
// tb_operand_forward_unit: directed table, reset-in-stall sequence and random run against a queue model
module tb_operand_forward_unit;
  localparam int DEPTH = 2;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic issue_valid = 1'b0, issue_wide = 1'b0, issue_late = 1'b0;
  logic [3:0] issue_dst = '0, src_reg = '0;
  logic [1:0] alusrc = 2'b01;
  logic [15:0] op2 = 16'h0A0A, seimmd = 16'h0005, r15 = 16'hF0F0;
  logic [31:0] sres [DEPTH];
  logic [DEPTH*32-1:0] stage_result;
  logic [15:0] result, stall_count;
  logic [1:0] fwd_stage;
  logic fwd_hi, stall;
  int vecs = 0, errs = 0;

  for (genvar k = 0; k < DEPTH; k++) begin : g_sr
    assign stage_result[k*32 +: 32] = sres[k];
  end

  operand_forward_unit #(.DW(16), .RW(4), .DEPTH(DEPTH), .HI_REG(0), .R15_REG(15)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .issue_valid(issue_valid), .issue_dst(issue_dst),
    .issue_wide(issue_wide), .issue_late(issue_late), .stage_result(stage_result),
    .src_reg(src_reg), .alusrc(alusrc), .op2(op2), .seimmd(seimmd), .r15(r15),
    .result(result), .fwd_stage(fwd_stage), .fwd_hi(fwd_hi), .stall(stall),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // in-flight producers, newest first; entry k is the producer k+1 stages ahead
  typedef struct {bit v; bit [3:0] d; bit w; bit l;} rec_t;
  rec_t pipe[$];
  int mcnt;

  task automatic model_clear();
    pipe.delete();
    repeat (DEPTH) pipe.push_back('{v: 1'b0, d: 4'd0, w: 1'b0, l: 1'b0});
    mcnt = 0;
  endtask

  task automatic predict(output logic [15:0] r, output logic [1:0] fs, output logic fh, output logic st);
    logic [3:0] a;
    bit look;
    look = alusrc == 2'b00 || alusrc == 2'b10;
    a = alusrc == 2'b10 ? 4'd15 : src_reg;
    r = alusrc == 2'b00 ? op2 : alusrc == 2'b01 ? seimmd : alusrc == 2'b10 ? r15 : 16'h0000;
    fs = 2'd0;
    fh = 1'b0;
    st = look && pipe[0].v && pipe[0].l && (pipe[0].d == a || (pipe[0].w && a == 4'd0));
    if (look && !st)
      for (int k = 0; k < DEPTH; k++)
        if (pipe[k].v && (pipe[k].d == a || (pipe[k].w && a == 4'd0))) begin
          fh = pipe[k].d != a;
          r = fh ? sres[k][31:16] : sres[k][15:0];
          fs = 2'(k + 1);
          break;
        end
  endtask

  task automatic commit(input logic st);
    if (flush) foreach (pipe[i]) pipe[i].v = 1'b0;
    pipe.push_front('{v: issue_valid && !st && !flush, d: issue_dst, w: issue_wide, l: issue_late});
    void'(pipe.pop_back());
    if (st && mcnt < 65535) mcnt++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {int iv; int dst; int w; int l; int fl; int src; int as; int er; int ef; int eh; int es; int ec;} vec_t;
  vec_t tbl[18];

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] er;
    logic [1:0] ef;
    logic eh, es;
    logic [3:0] pick [4];
    tbl[0]  = '{0, 0, 0, 0, 0,  0, 1, 'h0005, 0, 0, 0, 0};
    tbl[1]  = '{1, 3, 0, 0, 0,  3, 0, 'h0A0A, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0,  3, 0, 'hABCD, 1, 0, 0, 0};
    tbl[3]  = '{1, 5, 1, 0, 0,  1, 0, 'h0A0A, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0,  5, 0, 'hABCD, 1, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0,  0, 0, 'h1234, 2, 1, 0, 0};
    tbl[6]  = '{1, 7, 0, 1, 0,  9, 0, 'h0A0A, 0, 0, 0, 0};
    tbl[7]  = '{1, 8, 0, 0, 0,  7, 0, 'h0A0A, 0, 0, 1, 0};
    tbl[8]  = '{1, 8, 0, 0, 0,  7, 0, 'h5678, 2, 0, 0, 1};
    tbl[9]  = '{1, 2, 0, 0, 0,  0, 1, 'h0005, 0, 0, 0, 1};
    tbl[10] = '{1, 2, 0, 0, 0,  2, 0, 'hABCD, 1, 0, 0, 1};
    tbl[11] = '{1, 4, 0, 0, 1,  2, 0, 'hABCD, 1, 0, 0, 1};
    tbl[12] = '{0, 0, 0, 0, 0,  2, 0, 'h0A0A, 0, 0, 0, 1};
    tbl[13] = '{1, 15, 0, 0, 0, 0, 2, 'hF0F0, 0, 0, 0, 1};
    tbl[14] = '{0, 0, 0, 0, 0,  0, 2, 'hABCD, 1, 0, 0, 1};
    tbl[15] = '{0, 0, 0, 0, 0, 15, 3, 'h0000, 0, 0, 0, 1};
    tbl[16] = '{1, 0, 1, 0, 0,  0, 2, 'hF0F0, 0, 0, 0, 1};
    tbl[17] = '{0, 0, 0, 0, 0,  0, 0, 'hABCD, 1, 0, 0, 1};
    pick = '{4'd0, 4'd2, 4'd7, 4'd15};
    sres[0] = 32'hCAFE_ABCD;
    sres[1] = 32'h1234_5678;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset stall_count", 32'(stall_count), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      issue_valid = tbl[i].iv[0];
      issue_dst   = 4'(tbl[i].dst);
      issue_wide  = tbl[i].w[0];
      issue_late  = tbl[i].l[0];
      flush       = tbl[i].fl[0];
      src_reg     = 4'(tbl[i].src);
      alusrc      = 2'(tbl[i].as);
      #2;
      chk($sformatf("row%0d result", i), 32'(result), 32'(tbl[i].er));
      chk($sformatf("row%0d fwd_stage", i), 32'(fwd_stage), 32'(tbl[i].ef));
      chk($sformatf("row%0d fwd_hi", i), 32'(fwd_hi), 32'(tbl[i].eh));
      chk($sformatf("row%0d stall", i), 32'(stall), 32'(tbl[i].es));
      chk($sformatf("row%0d stall_count", i), 32'(stall_count), 32'(tbl[i].ec));
      predict(er, ef, eh, es);
      commit(es);
      @(posedge clk);
      #1;
    end
    flush = 1'b0;

    issue_valid = 1'b1; issue_dst = 4'd7; issue_wide = 1'b0; issue_late = 1'b1; alusrc = 2'b01;
    #2;
    predict(er, ef, eh, es);
    commit(es);
    @(posedge clk);
    #1;
    issue_valid = 1'b0; src_reg = 4'd7; alusrc = 2'b00;
    #2;
    chk("rst seq stall before", 32'(stall), 32'd1);
    chk("rst seq count before", 32'(stall_count), 32'd1);
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst seq stall", 32'(stall), 32'd0);
    chk("rst seq count", 32'(stall_count), 32'd0);
    chk("rst seq result", 32'(result), 32'h0A0A);
    chk("rst seq fwd_stage", 32'(fwd_stage), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post rst result", 32'(result), 32'h0A0A);
    chk("post rst stall", 32'(stall), 32'd0);
    predict(er, ef, eh, es);
    commit(es);
    @(posedge clk);
    #1;

    for (int n = 0; n < 3000; n++) begin
      issue_valid = $urandom_range(0, 3) != 0;
      issue_dst   = $urandom_range(0, 3) == 0 ? 4'($urandom) : pick[$urandom_range(0, 3)];
      issue_wide  = $urandom_range(0, 3) == 0;
      issue_late  = $urandom_range(0, 2) == 0;
      flush       = $urandom_range(0, 15) == 0;
      src_reg     = $urandom_range(0, 3) == 0 ? 4'($urandom) : pick[$urandom_range(0, 3)];
      alusrc      = 2'($urandom);
      op2         = 16'($urandom);
      seimmd      = 16'($urandom);
      r15         = 16'($urandom);
      sres[0]     = $urandom;
      sres[1]     = $urandom;
      #2;
      predict(er, ef, eh, es);
      chk($sformatf("rnd%0d result", n), 32'(result), 32'(er));
      chk($sformatf("rnd%0d fwd_stage", n), 32'(fwd_stage), 32'(ef));
      chk($sformatf("rnd%0d fwd_hi", n), 32'(fwd_hi), 32'(eh));
      chk($sformatf("rnd%0d stall", n), 32'(stall), 32'(es));
      chk($sformatf("rnd%0d stall_count", n), 32'(stall_count), 32'(mcnt));
      commit(es);
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
